// File: rtl/ltc2358_pkg.sv
// Shared constants for the LTC2358 conversion sequencer: frame geometry,
// FSM state encodings and the result-word channel field.
package ltc2358_pkg;

    localparam int NUM_CH     = 8;
    localparam int WORD_BITS  = 24;
    localparam int FRAME_BITS = NUM_CH * WORD_BITS;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CNV       = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Result word layout: {data[17:0], chan_id[2:0], span[2:0]}
    localparam int CHAN_MSB = 5;
    localparam int CHAN_LSB = 3;

    function automatic logic [2:0] chan_of(input logic [WORD_BITS-1:0] word);
        return word[CHAN_MSB:CHAN_LSB];
    endfunction

endpackage

// File: rtl/ltc2358_sck_gen.sv
// SCKI divider: SCK_HALF cycles low then SCK_HALF high, idling low while disabled.
// rise_en/fall_en mark the last cycle before scki rises/falls.
module ltc2358_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic scki,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc      = en && (cnt == '0);
    assign rise_en = tc & ~scki;
    assign fall_en = tc & scki;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RELOAD;
            scki <= 1'b0;
        end else if (!en) begin
            cnt  <= RELOAD;
            scki <= 1'b0;
        end else if (tc) begin
            cnt  <= RELOAD;
            scki <= ~scki;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ltc2358_conv_seq.sv
// LTC2358 conversion sequencer: CNV pulse, BUSY wait, 192-bit SDO0 readout with
// SoftSpan on SDI, and per-word valid/ready result delivery with sticky errors.
//
// state      | meaning
// IDLE       | waiting for a start or periodic trigger
// CNV        | adc_cnv high for CNV_HIGH cycles
// WAIT_BUSY  | blank 3 cycles, then wait for BUSY low or timeout
// SHIFT      | 192 SCKI periods, SDO0 in, SoftSpan out
// DONE       | one cycle, bump frame_cnt
module ltc2358_conv_seq
    import ltc2358_pkg::*;
#(
    parameter int SCK_HALF = 2,
    parameter int CNV_HIGH = 4,
    parameter int BUSY_TMO = 1000
) (
    input  logic        s00_axi_aclk,
    input  logic        s00_axi_aresetn,
    input  logic        cfg_enable,
    input  logic        cfg_start,
    input  logic        cfg_continuous,
    input  logic [31:0] cfg_period,
    input  logic [23:0] cfg_softspan,
    input  logic        cfg_clr_err,
    output logic        adc_cnv,
    input  logic        adc_busy,
    output logic        adc_scki,
    output logic        adc_sdi,
    input  logic        adc_sdo0,
    output logic [23:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        seq_active,
    output logic [15:0] frame_cnt,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        err_missed,
    output logic        err_chan_id
);

    localparam int WIW = $clog2(NUM_CH);

    logic [2:0]           state;
    logic [1:0]           busy_ff;
    logic                 busy_sync;
    logic [31:0]          per_cnt;
    logic [15:0]          cnv_cnt;
    logic [15:0]          wait_cnt;
    logic [4:0]           bit_idx;
    logic [WIW-1:0]       word_idx;
    logic [4:0]           sdi_idx;
    logic [7:0]           fall_cnt;
    logic [22:0]          shreg;
    logic [23:0]          span_lat;
    logic [23:0]          word_in;
    logic                 rise_en, fall_en, scki;
    logic                 per_run, per_trig, trig, go;
    logic                 busy_ok, word_end, last_fall;
    logic                 timeout_evt, overrun_evt, missed_evt, chan_evt;

    assign busy_sync  = busy_ff[1];
    assign seq_active = (state != ST_IDLE);
    assign adc_cnv    = (state == ST_CNV);
    assign adc_scki   = scki;
    assign adc_sdi    = (state == ST_SHIFT) & span_lat[sdi_idx];

    assign per_run  = cfg_enable & cfg_continuous;
    assign per_trig = per_run & (per_cnt == cfg_period - 32'd1);
    assign trig     = per_trig | (cfg_enable & cfg_start);
    assign go       = trig & ~seq_active;

    // Wait counter runs down from BUSY_TMO-1; the first three values are the blanking window.
    assign busy_ok     = (state == ST_WAIT_BUSY) && (wait_cnt <= 16'(BUSY_TMO - 4)) && !busy_sync;
    assign timeout_evt = (state == ST_WAIT_BUSY) && !busy_ok && (wait_cnt == 16'd0);

    assign word_in   = {shreg, adc_sdo0};
    assign word_end  = rise_en && (bit_idx == 5'(WORD_BITS - 1));
    assign last_fall = fall_en && (fall_cnt == 8'(FRAME_BITS - 1));

    assign overrun_evt = word_end & res_valid & ~res_ready;
    assign chan_evt    = word_end && (chan_of(word_in) != 3'(word_idx));
    assign missed_evt  = per_trig & seq_active;

    ltc2358_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck_gen (
        .clk     (s00_axi_aclk),
        .rst_n   (s00_axi_aresetn),
        .en      (state == ST_SHIFT),
        .scki    (scki),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            busy_ff <= 2'b00;
            per_cnt <= '0;
        end else begin
            busy_ff <= {busy_ff[0], adc_busy};
            if (trig || !per_run)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + 32'd1;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state     <= ST_IDLE;
            cnv_cnt   <= '0;
            wait_cnt  <= '0;
            bit_idx   <= '0;
            word_idx  <= '0;
            sdi_idx   <= '0;
            fall_cnt  <= '0;
            shreg     <= '0;
            span_lat  <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (go) begin
                    state    <= ST_CNV;
                    cnv_cnt  <= 16'(CNV_HIGH - 1);
                    span_lat <= cfg_softspan;
                end
                ST_CNV: if (cnv_cnt == 16'd0) begin
                    state    <= ST_WAIT_BUSY;
                    wait_cnt <= 16'(BUSY_TMO - 1);
                end else begin
                    cnv_cnt <= cnv_cnt - 16'd1;
                end
                ST_WAIT_BUSY: if (busy_ok) begin
                    state    <= ST_SHIFT;
                    bit_idx  <= '0;
                    word_idx <= '0;
                    sdi_idx  <= 5'(WORD_BITS - 1);
                    fall_cnt <= '0;
                end else if (wait_cnt == 16'd0) begin
                    state <= ST_IDLE;
                end else begin
                    wait_cnt <= wait_cnt - 16'd1;
                end
                ST_SHIFT: begin
                    if (rise_en) begin
                        shreg   <= word_in[22:0];
                        bit_idx <= word_end ? 5'd0 : bit_idx + 5'd1;
                        if (word_end)
                            word_idx <= word_idx + WIW'(1);
                    end
                    if (fall_en) begin
                        sdi_idx  <= (sdi_idx == 5'd0) ? 5'(WORD_BITS - 1) : sdi_idx - 5'd1;
                        fall_cnt <= fall_cnt + 8'd1;
                        if (last_fall)
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            res_data  <= '0;
            res_valid <= 1'b0;
        end else if (word_end) begin
            res_data  <= word_in;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // A clear in the same cycle as a new event leaves the flag set.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_missed  <= 1'b0;
            err_chan_id <= 1'b0;
        end else begin
            err_timeout <= timeout_evt | (err_timeout & ~cfg_clr_err);
            err_overrun <= overrun_evt | (err_overrun & ~cfg_clr_err);
            err_missed  <= missed_evt  | (err_missed  & ~cfg_clr_err);
            err_chan_id <= chan_evt    | (err_chan_id & ~cfg_clr_err);
        end
    end

endmodule

// File: tb/tb_ltc2358_conv_seq.sv
// Bench for ltc2358_conv_seq: ADC pin model, scoreboard of result words,
// SDI capture and directed scenarios for periodic mode, timeout, overrun and reset.
`timescale 1ns/1ps
module tb_ltc2358_conv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_enable = 1'b0, cfg_start = 1'b0, cfg_continuous = 1'b0, cfg_clr_err = 1'b0;
    logic [31:0] cfg_period = 32'd0;
    logic [23:0] cfg_softspan = 24'd0;
    logic        adc_cnv, adc_busy, adc_scki, adc_sdi, adc_sdo0;
    logic [23:0] res_data;
    logic        res_valid, res_ready = 1'b0, seq_active;
    logic [15:0] frame_cnt;
    logic        err_timeout, err_overrun, err_missed, err_chan_id;
    logic [3:0]  errs;

    assign errs = {err_timeout, err_overrun, err_missed, err_chan_id};

    always #5 clk = ~clk;

    ltc2358_conv_seq #(.SCK_HALF(2), .CNV_HIGH(4), .BUSY_TMO(1000)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .cfg_enable(cfg_enable), .cfg_start(cfg_start), .cfg_continuous(cfg_continuous),
        .cfg_period(cfg_period), .cfg_softspan(cfg_softspan), .cfg_clr_err(cfg_clr_err),
        .adc_cnv(adc_cnv), .adc_busy(adc_busy), .adc_scki(adc_scki), .adc_sdi(adc_sdi),
        .adc_sdo0(adc_sdo0), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .seq_active(seq_active), .frame_cnt(frame_cnt), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .err_missed(err_missed), .err_chan_id(err_chan_id)
    );

    // Hand-computed words {18'h30000+k, k, 3'b111}; BAD3 carries chan_id 5 in slot 3
    localparam logic [23:0] EXP [8] = '{24'hC00007, 24'hC0004F, 24'hC00097, 24'hC000DF,
                                        24'hC00127, 24'hC0016F, 24'hC001B7, 24'hC001FF};
    localparam logic [23:0] EXP_BAD3 = 24'hC000EF;
    localparam logic [23:0] SPAN     = 24'hFAC688;

    int n_chk = 0, n_err = 0, cyc = 0;
    logic [23:0] expq[$];
    int          cnv_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model
    logic hang = 1'b0, bad_chan = 1'b0, hold_mode = 1'b0;
    int   bcnt;
    logic [7:0]  bidx = 8'd0;
    logic [23:0] cur_w;

    function automatic logic [23:0] model_word(input int k);
        logic [2:0] ch;
        ch = 3'(k);
        if (bad_chan && k == 3) ch = 3'd5;
        return {18'h30000 + 18'(k), ch, 3'b111};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_busy <= 1'b0;
            bcnt     <= 0;
        end else if (adc_cnv) begin
            adc_busy <= 1'b1;
            bcnt     <= 20;
        end else if (adc_busy && !hang) begin
            if (bcnt == 0) adc_busy <= 1'b0;
            else           bcnt <= bcnt - 1;
        end
    end

    always @(negedge adc_scki or posedge adc_cnv) begin
        if (adc_cnv) bidx <= 8'd0;
        else         bidx <= bidx + 8'd1;
    end

    always_comb begin
        cur_w    = model_word(int'(bidx) / 24);
        adc_sdo0 = (bidx < 8'd192) ? cur_w[23 - int'(bidx) % 24] : 1'b0;
    end

    // Expected words are queued when the conversion is issued
    always @(posedge adc_cnv) begin
        cnv_cyc.push_back(cyc);
        if (!hang) begin
            if (hold_mode) expq.push_back(EXP[7]);
            else for (int k = 0; k < 8; k++)
                expq.push_back((bad_chan && k == 3) ? EXP_BAD3 : EXP[k]);
        end
    end

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_extra: got %h with nothing expected", res_data);
            end else begin
                check("sb_word", res_data, expq.pop_front());
            end
        end
    end

    logic [23:0] sdi_sh = 24'd0;
    int          sdi_n = 0;
    always @(posedge adc_scki or posedge adc_cnv) begin
        if (adc_cnv) sdi_n = 0;
        else begin
            sdi_sh = {sdi_sh[22:0], adc_sdi};
            sdi_n++;
            if (sdi_n % 24 == 0) check("sdi_word", sdi_sh, SPAN);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick(1); cfg_start = 1'b1; tick(1); cfg_start = 1'b0;
    endtask

    task automatic pulse_clr();
        tick(1); cfg_clr_err = 1'b1; tick(1); cfg_clr_err = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (seq_active && t < 3000) begin tick(1); t++; end
        if (t >= 3000) fail_now(name);
    endtask

    task automatic wait_frame(input string name);
        int t = 0;
        while (!seq_active && t < 3000) begin tick(1); t++; end
        if (t >= 3000) fail_now(name);
        else wait_idle(name);
        tick(5);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d;
        tick(3);
        check("rst_cnv", adc_cnv, 0);
        check("rst_scki", adc_scki, 0);
        check("rst_sdi", adc_sdi, 0);
        check("rst_valid", res_valid, 0);
        check("rst_active", seq_active, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_errs", errs, 0);
        check("rst_data", res_data, 0);

        rst_n = 1'b1; cfg_enable = 1'b1; res_ready = 1'b1; cfg_softspan = SPAN;
        tick(2);

        // Single frame, clean
        pulse_start();
        wait_frame("t1_frame");
        check("t1_drained", expq.size(), 0);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_errs", errs, 0);

        // Channel mismatch in word 3
        bad_chan = 1'b1;
        pulse_start();
        wait_frame("chan_frame");
        bad_chan = 1'b0;
        check("chan_err", err_chan_id, 1);
        check("chan_no_overrun", err_overrun, 0);
        check("chan_frame_cnt", frame_cnt, 2);
        pulse_clr();
        check("chan_cleared", err_chan_id, 0);

        // Consumer stalls a whole frame
        res_ready = 1'b0; hold_mode = 1'b1;
        pulse_start();
        wait_frame("ovr_frame");
        hold_mode = 1'b0;
        check("ovr_err", err_overrun, 1);
        check("ovr_valid", res_valid, 1);
        check("ovr_data", res_data, EXP[7]);
        check("ovr_no_chan", err_chan_id, 0);
        res_ready = 1'b1;
        tick(3);
        check("ovr_drained", expq.size(), 0);
        check("ovr_valid_drop", res_valid, 0);
        pulse_clr();
        check("ovr_cleared", err_overrun, 0);

        // BUSY never falls
        hang = 1'b1;
        pulse_start();
        t = 0;
        while (!err_timeout && t < 1200) begin tick(1); t++; end
        if (t >= 1200) fail_now("tmo_wait");
        else begin
            d = cyc - cnv_cyc[cnv_cyc.size()-1];
            check("tmo_delay_in_window", (d >= 1000 && d <= 1010), 1);
        end
        check("tmo_idle", seq_active, 0);
        check("tmo_frame_cnt", frame_cnt, 3);
        pulse_clr();
        check("tmo_cleared", err_timeout, 0);
        hang = 1'b0;
        tick(30);

        // Periodic triggering
        cnv_cyc.delete();
        cfg_period = 32'd2000; cfg_continuous = 1'b1;
        t = 0;
        while (cnv_cyc.size() < 3 && t < 7000) begin tick(1); t++; end
        cfg_continuous = 1'b0;
        if (t >= 7000) fail_now("per_wait");
        else begin
            check("per_gap1", cnv_cyc[1] - cnv_cyc[0], 2000);
            check("per_gap2", cnv_cyc[2] - cnv_cyc[1], 2000);
        end
        wait_idle("per_idle");
        check("per_no_missed", err_missed, 0);

        cfg_period = 32'd500; cfg_continuous = 1'b1;
        t = 0;
        while (!err_missed && t < 3000) begin tick(1); t++; end
        cfg_continuous = 1'b0;
        check("missed_set", err_missed, 1);
        wait_idle("missed_idle");
        tick(5);
        check("missed_drained", expq.size(), 0);
        pulse_clr();
        check("missed_cleared", err_missed, 0);

        // Reset in the middle of SHIFT
        pulse_start();
        t = 0;
        while (!adc_scki && t < 500) begin tick(1); t++; end
        if (t >= 500) fail_now("rst_scki_wait");
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnv", adc_cnv, 0);
        check("mid_rst_scki", adc_scki, 0);
        check("mid_rst_sdi", adc_sdi, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_active", seq_active, 0);
        expq.delete();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        pulse_start();
        wait_frame("post_rst_frame");
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_errs", errs, 0);
        check("post_rst_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
